// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small transmit FIFO
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        txd
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          sel_tx, sel_st, full, empty, push, pop, baud_end;
  logic [31:0]   status;
  logic          unused_wdata;

  assign sel_tx   = aluout == BASE_ADDR;
  assign sel_st   = aluout == STATUS_ADDR;
  assign full     = count_q == DEPTH;
  assign empty    = count_q == '0;
  assign push     = memwrite && sel_tx && !full;
  assign baud_end = baud_q == BAUD_LAST;
  assign status   = {23'd0, 5'(count_q), ovf_q, state_q != IDLE, empty, full};
  assign readdata = sel_st ? status : 32'd0;
  assign hit      = sel_tx || sel_st;
  assign txd      = txd_q;
  assign unused_wdata = ^writedata[31:8];

  // FIFO bookkeeping: fullness is judged on the pre-edge count, so a pop cannot make room for a same-edge write
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = (memwrite && sel_tx && full) ? 1'b1 :
               (memwrite && sel_st && writedata[3]) ? 1'b0 : ovf_q;
  end

  // transmit FSM: txd_d is the line level for the state being entered, keeping txd a clean register output
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = START;
        baud_d  = '0;
        shift_d = fifo_q[rd_ptr_q];
        txd_d   = 1'b0;
      end
      START: if (baud_end) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = 3'd0;
        txd_d   = shift_q[0];
      end else baud_d = baud_q + BW'(1);
      DATA: if (baud_end) begin
        baud_d  = '0;
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d   = bit_q == 3'd7 ? bit_q : bit_q + 3'd1;
        txd_d   = bit_q == 3'd7 ? 1'b1 : shift_q[bit_q + 3'd1];
      end else baud_d = baud_q + BW'(1);
      STOP: if (baud_end) begin
        baud_d  = '0;
        pop     = !empty;
        state_d = empty ? IDLE : START;
        shift_d = empty ? shift_q : fifo_q[rd_ptr_q];
        txd_d   = empty;
      end else baud_d = baud_q + BW'(1);
    endcase
  end

  // FIFO storage needs no reset: the cleared count makes stale entries unreachable
  always_ff @(posedge clk)
    if (push) fifo_q[wr_ptr_q] <= writedata[7:0];

  // state registers; reset aborts any frame and empties the FIFO
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
endmodule
